// File: rtl/alu_multiciclo_if.sv
// ============================================================================
// Module   : alu_multiciclo_if
// Purpose  : Start/done handshake and operand/result bus of the multi-cycle ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_multiciclo_if #(
  parameter int LARGURA = 16
);
  logic               inicio;
  logic [LARGURA-1:0] entrada1;
  logic [LARGURA-1:0] entrada2;
  logic [2:0]         sinal_ula;
  logic [LARGURA-1:0] saida_ula;
  logic [LARGURA-1:0] saida_hi;
  logic               zero;
  logic               overflow;
  logic               div_zero;
  logic               ocupado;
  logic               pronto;

  modport master (
    output inicio, entrada1, entrada2, sinal_ula,
    input  saida_ula, saida_hi, zero, overflow, div_zero, ocupado, pronto
  );

  modport slave (
    input  inicio, entrada1, entrada2, sinal_ula,
    output saida_ula, saida_hi, zero, overflow, div_zero, ocupado, pronto
  );
endinterface

`default_nettype wire

// File: rtl/alu_multiciclo.sv
// ============================================================================
// Module   : alu_multiciclo
// Purpose  : EX-stage ALU with single-cycle logic/arith ops and iterative MULTU/DIVU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_multiciclo #(
  parameter int LARGURA = 16
) (
  input  wire logic     clock,
  input  wire logic     reset_n,
  alu_multiciclo_if.slave bus
);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] MULT   = 2'd1;
  localparam logic [1:0] DIV    = 2'd2;
  localparam logic [1:0] FIM    = 2'd3;

  localparam logic [LARGURA-1:0] c_ULTIMO = LARGURA'(LARGURA - 1);

  logic [1:0]           r_estado, w_prox;
  logic [LARGURA-1:0]   r_cnt;
  logic [LARGURA-1:0]   r_opnd;
  logic [2*LARGURA-1:0] r_acc;

  logic [LARGURA-1:0]   r_saida, r_hi;
  logic                 r_zero, r_ov, r_dz, r_pronto, r_ocupado;

  logic w_aceita, w_ld_unico, w_ini_mult, w_ini_div;
  logic w_passo_mult, w_passo_div, w_fim_mult, w_fim_div;

  logic [LARGURA-1:0] w_a, w_b, w_soma, w_dif, w_res, w_hi;
  logic               w_ov, w_dz;

  logic [LARGURA:0]     w_mult_soma;
  logic [2*LARGURA-1:0] w_acc_mult;
  logic [LARGURA:0]     w_div_desl, w_div_tent;
  logic [2*LARGURA-1:0] w_acc_div;

  assign w_a    = bus.entrada1;
  assign w_b    = bus.entrada2;
  assign w_soma = w_a + w_b;
  assign w_dif  = w_a - w_b;

  assign w_aceita = bus.inicio && ((r_estado == OCIOSO) || (r_estado == FIM));

  // Shift-add: acc = {partial high, remaining multiplier bits}.
  assign w_mult_soma = {1'b0, r_acc[2*LARGURA-1:LARGURA]}
                     + (r_acc[0] ? {1'b0, r_opnd} : {(LARGURA+1){1'b0}});
  assign w_acc_mult  = {w_mult_soma, r_acc[LARGURA-1:1]};

  // Restoring division: acc = {remainder, dividend bits shifting into quotient}.
  assign w_div_desl = {r_acc[2*LARGURA-1:LARGURA], r_acc[LARGURA-1]};
  assign w_div_tent = w_div_desl - {1'b0, r_opnd};
  assign w_acc_div  = w_div_tent[LARGURA]
                    ? {w_div_desl[LARGURA-1:0], r_acc[LARGURA-2:0], 1'b0}
                    : {w_div_tent[LARGURA-1:0], r_acc[LARGURA-2:0], 1'b1};

  always_comb begin
    w_res = '0;
    w_hi  = '0;
    w_ov  = 1'b0;
    w_dz  = 1'b0;
    case (bus.sinal_ula)
      3'b000: w_res = w_a & w_b;
      3'b001: w_res = w_a | w_b;
      3'b010: begin
        w_res = w_soma;
        w_ov  = (w_a[LARGURA-1] == w_b[LARGURA-1]) && (w_soma[LARGURA-1] != w_a[LARGURA-1]);
      end
      3'b011: begin
        w_res = w_dif;
        w_ov  = (w_a[LARGURA-1] != w_b[LARGURA-1]) && (w_dif[LARGURA-1] != w_a[LARGURA-1]);
      end
      3'b100: w_res = {{(LARGURA-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      3'b101: w_res = {{(LARGURA-1){1'b0}}, (w_a < w_b)};
      3'b111: begin
        w_res = '1;
        w_hi  = w_a;
        w_dz  = 1'b1;
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_estado <= OCIOSO;
    else          r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO, FIM: begin
        if (w_aceita) begin
          case (bus.sinal_ula)
            3'b110:  w_prox = MULT;
            3'b111:  w_prox = (bus.entrada2 != '0) ? DIV : FIM;
            default: w_prox = FIM;
          endcase
        end else begin
          w_prox = OCIOSO;
        end
      end
      MULT:    w_prox = (r_cnt == c_ULTIMO) ? FIM : MULT;
      DIV:     w_prox = (r_cnt == c_ULTIMO) ? FIM : DIV;
      default: w_prox = OCIOSO;
    endcase
  end

  always_comb begin
    w_ld_unico   = w_aceita && (w_prox == FIM);
    w_ini_mult   = w_aceita && (w_prox == MULT);
    w_ini_div    = w_aceita && (w_prox == DIV);
    w_passo_mult = (r_estado == MULT);
    w_passo_div  = (r_estado == DIV);
    w_fim_mult   = w_passo_mult && (r_cnt == c_ULTIMO);
    w_fim_div    = w_passo_div  && (r_cnt == c_ULTIMO);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_saida   <= '0;
      r_hi      <= '0;
      r_zero    <= 1'b1;
      r_ov      <= 1'b0;
      r_dz      <= 1'b0;
      r_pronto  <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_pronto  <= (w_prox == FIM);
      r_ocupado <= (w_prox == MULT) || (w_prox == DIV);
      if (w_ini_mult) begin
        r_opnd <= bus.entrada1;
        r_acc  <= {{LARGURA{1'b0}}, bus.entrada2};
        r_cnt  <= '0;
      end else if (w_ini_div) begin
        r_opnd <= bus.entrada2;
        r_acc  <= {{LARGURA{1'b0}}, bus.entrada1};
        r_cnt  <= '0;
      end else if (w_passo_mult) begin
        r_acc <= w_acc_mult;
        r_cnt <= r_cnt + 1'b1;
      end else if (w_passo_div) begin
        r_acc <= w_acc_div;
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_ld_unico) begin
        r_saida <= w_res;
        r_hi    <= w_hi;
        r_zero  <= (w_res == '0);
        r_ov    <= w_ov;
        r_dz    <= w_dz;
      end else if (w_fim_mult || w_fim_div) begin
        r_saida <= w_fim_mult ? w_acc_mult[LARGURA-1:0] : w_acc_div[LARGURA-1:0];
        r_hi    <= w_fim_mult ? w_acc_mult[2*LARGURA-1:LARGURA]
                              : w_acc_div[2*LARGURA-1:LARGURA];
        r_zero  <= w_fim_mult ? (w_acc_mult[LARGURA-1:0] == '0)
                              : (w_acc_div[LARGURA-1:0] == '0);
        r_ov    <= 1'b0;
        r_dz    <= 1'b0;
      end
    end
  end

  assign bus.saida_ula = r_saida;
  assign bus.saida_hi  = r_hi;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_ov;
  assign bus.div_zero  = r_dz;
  assign bus.pronto    = r_pronto;
  assign bus.ocupado   = r_ocupado;

endmodule

`default_nettype wire

// File: tb/tb_alu_multiciclo.sv
// ============================================================================
// Module   : tb_alu_multiciclo
// Purpose  : Directed self-checking bench for alu_multiciclo (LARGURA = 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_multiciclo;

  localparam int W = 16;

  logic clock;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  alu_multiciclo_if #(.LARGURA(W)) bus();

  alu_multiciclo #(.LARGURA(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one request; returns 1 time unit after the acceptance edge (cycle 1).
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clock); #1;
    bus.inicio    = 1'b1;
    bus.sinal_ula = op;
    bus.entrada1  = a;
    bus.entrada2  = b;
    @(posedge clock); #1;
    bus.inicio = 1'b0;
  endtask

  // Starting in cycle 1, counts busy cycles until pronto (bounded).
  task automatic run_until_pronto(output int pr_cyc, output int n_busy, output bit both);
    int cyc = 1;
    pr_cyc = 0; n_busy = 0; both = 1'b0;
    while (pr_cyc == 0 && cyc < 40) begin
      if (bus.pronto && bus.ocupado) both = 1'b1;
      if (bus.ocupado) n_busy++;
      if (bus.pronto) pr_cyc = cyc;
      else begin
        if (cyc == 3) begin
          bus.entrada1  = 16'hFFFF;
          bus.entrada2  = 16'h0001;
          bus.sinal_ula = 3'b000;
        end
        @(posedge clock); #1;
        cyc++;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.saida_ula !== 16'h0 || bus.saida_hi !== 16'h0 || bus.zero !== 1'b1 ||
        bus.overflow !== 1'b0 || bus.div_zero !== 1'b0 || bus.pronto !== 1'b0 || bus.ocupado !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ula=%h hi=%h z=%b ov=%b dz=%b pr=%b oc=%b required 0000 0000 1 0 0 0 0",
               bus.saida_ula, bus.saida_hi, bus.zero, bus.overflow, bus.div_zero, bus.pronto, bus.ocupado);
    end
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    bit busy_seen = 1'b0;
    @(posedge clock); #1;
    bus.inicio = 1'b1; bus.sinal_ula = 3'b000; bus.entrada1 = 16'h0006; bus.entrada2 = 16'h0003;
    @(posedge clock); #1;
    busy_seen |= bus.ocupado;
    checks++;
    if (bus.pronto !== 1'b1 || bus.saida_ula !== 16'h0002) begin
      errors++;
      $display("FAIL and_b2b: pronto=%b ula=%h required 1 0002", bus.pronto, bus.saida_ula);
    end
    bus.sinal_ula = 3'b001; bus.entrada1 = 16'h0004; bus.entrada2 = 16'h000B;
    @(posedge clock); #1;
    bus.inicio = 1'b0;
    busy_seen |= bus.ocupado;
    checks++;
    if (bus.pronto !== 1'b1 || bus.saida_ula !== 16'h000F || bus.saida_hi !== 16'h0) begin
      errors++;
      $display("FAIL or_b2b: pronto=%b ula=%h hi=%h required 1 000F 0000", bus.pronto, bus.saida_ula, bus.saida_hi);
    end
    @(posedge clock); #1;
    busy_seen |= bus.ocupado;
    checks++;
    if (bus.pronto !== 1'b0 || busy_seen !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail: pronto=%b busy_seen=%b required 0 0", bus.pronto, busy_seen);
    end
  endtask

  task automatic test_addsub;
    start_op(3'b010, 16'h7FFF, 16'h0001);
    checks++;
    if (bus.pronto !== 1'b1 || bus.saida_ula !== 16'h8000 || bus.overflow !== 1'b1 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf: pr=%b ula=%h ov=%b z=%b required 1 8000 1 0",
               bus.pronto, bus.saida_ula, bus.overflow, bus.zero);
    end
    start_op(3'b011, 16'h0004, 16'h0004);
    checks++;
    if (bus.pronto !== 1'b1 || bus.saida_ula !== 16'h0000 || bus.overflow !== 1'b0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero: pr=%b ula=%h ov=%b z=%b required 1 0000 0 1",
               bus.pronto, bus.saida_ula, bus.overflow, bus.zero);
    end
    start_op(3'b011, 16'h8000, 16'h0001);
    checks++;
    if (bus.saida_ula !== 16'h7FFF || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: ula=%h ov=%b required 7FFF 1", bus.saida_ula, bus.overflow);
    end
  endtask

  task automatic test_slt;
    start_op(3'b100, 16'hFFFF, 16'h0001);
    checks++;
    if (bus.pronto !== 1'b1 || bus.saida_ula !== 16'h0001 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL slt: pr=%b ula=%h z=%b required 1 0001 0", bus.pronto, bus.saida_ula, bus.zero);
    end
    start_op(3'b101, 16'hFFFF, 16'h0001);
    checks++;
    if (bus.pronto !== 1'b1 || bus.saida_ula !== 16'h0000 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL sltu: pr=%b ula=%h z=%b required 1 0000 1", bus.pronto, bus.saida_ula, bus.zero);
    end
  endtask

  task automatic test_multu;
    int pr_cyc, n_busy; bit both;
    start_op(3'b110, 16'h0123, 16'h0456);
    run_until_pronto(pr_cyc, n_busy, both);
    checks++;
    if (pr_cyc !== 17 || n_busy !== 16 || both !== 1'b0) begin
      errors++;
      $display("FAIL multu_timing: pronto_cycle=%0d busy=%0d both=%b required 17 16 0", pr_cyc, n_busy, both);
    end
    checks++;
    if (bus.saida_hi !== 16'h0004 || bus.saida_ula !== 16'hEDC2 || bus.overflow !== 1'b0 ||
        bus.div_zero !== 1'b0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL multu_result: hi=%h lo=%h ov=%b dz=%b z=%b required 0004 EDC2 0 0 0",
               bus.saida_hi, bus.saida_ula, bus.overflow, bus.div_zero, bus.zero);
    end
    @(posedge clock); #1;
    checks++;
    if (bus.pronto !== 1'b0 || bus.saida_ula !== 16'hEDC2) begin
      errors++;
      $display("FAIL multu_hold: pronto=%b lo=%h required 0 EDC2", bus.pronto, bus.saida_ula);
    end
  endtask

  task automatic test_divu;
    int pr_cyc, n_busy; bit both;
    start_op(3'b111, 16'h0017, 16'h0004);
    run_until_pronto(pr_cyc, n_busy, both);
    checks++;
    if (pr_cyc !== 17 || n_busy !== 16 || both !== 1'b0) begin
      errors++;
      $display("FAIL divu_timing: pronto_cycle=%0d busy=%0d both=%b required 17 16 0", pr_cyc, n_busy, both);
    end
    checks++;
    if (bus.saida_ula !== 16'h0005 || bus.saida_hi !== 16'h0003 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL divu_result: q=%h r=%h dz=%b required 0005 0003 0", bus.saida_ula, bus.saida_hi, bus.div_zero);
    end
  endtask

  task automatic test_divzero;
    start_op(3'b111, 16'h1234, 16'h0000);
    checks++;
    if (bus.pronto !== 1'b1 || bus.ocupado !== 1'b0 || bus.saida_ula !== 16'hFFFF ||
        bus.saida_hi !== 16'h1234 || bus.div_zero !== 1'b1 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL divzero: pr=%b oc=%b q=%h r=%h dz=%b z=%b required 1 0 FFFF 1234 1 0",
               bus.pronto, bus.ocupado, bus.saida_ula, bus.saida_hi, bus.div_zero, bus.zero);
    end
  endtask

  task automatic test_reset_mid_mult;
    int n_pronto = 0;
    start_op(3'b110, 16'h0123, 16'h0456);
    repeat (4) begin @(posedge clock); #1; end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.saida_ula !== 16'h0 || bus.saida_hi !== 16'h0 || bus.zero !== 1'b1 ||
        bus.overflow !== 1'b0 || bus.div_zero !== 1'b0 || bus.pronto !== 1'b0 || bus.ocupado !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ula=%h hi=%h z=%b ov=%b dz=%b pr=%b oc=%b required 0000 0000 1 0 0 0 0",
               bus.saida_ula, bus.saida_hi, bus.zero, bus.overflow, bus.div_zero, bus.pronto, bus.ocupado);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (20) begin
      @(posedge clock); #1;
      if (bus.pronto || bus.ocupado) n_pronto++;
    end
    checks++;
    if (n_pronto !== 0) begin
      errors++;
      $display("FAIL no_pronto_after_reset: active_cycles=%0d required 0", n_pronto);
    end
    start_op(3'b010, 16'h0002, 16'h0003);
    checks++;
    if (bus.pronto !== 1'b1 || bus.saida_ula !== 16'h0005 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL add_after_reset: pr=%b ula=%h ov=%b required 1 0005 0", bus.pronto, bus.saida_ula, bus.overflow);
    end
  endtask

  initial begin
    bus.inicio    = 1'b0;
    bus.sinal_ula = 3'b000;
    bus.entrada1  = '0;
    bus.entrada2  = '0;
    test_reset();
    test_back_to_back();
    test_addsub();
    test_slt();
    test_multu();
    test_divu();
    test_divzero();
    test_reset_mid_mult();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised successor to the 16-bit single-cycle ALU of the MIPS datapath.
It keeps the logic and arithmetic operations (AND, OR, ADD, SUB, SLT) and adds unsigned compare, iterative unsigned multiply and iterative unsigned divide, the latter two producing a HI/LO result pair.
All operations are started by a start/done handshake and return registered results, so the control unit can stall on multi-cycle operations.
It sits in the EX stage in place of the combinational ALU.

## Interface
- LARGURA, 16, operand/result width in bits (legal range ≥ 4).
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- inicio  in  1  start request; sampled only when the block is not busy.
- entrada1  in  LARGURA  operand A; captured on acceptance.
- entrada2  in  LARGURA  operand B; captured on acceptance.
- sinal_ula  in  3  opcode; captured on acceptance.
  - 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (signed), 101 SLTU, 110 MULTU, 111 DIVU.
- saida_ula  out  LARGURA  result.
  - Product low half for MULTU; quotient for DIVU.
- saida_hi  out  LARGURA  product high half (MULTU) or remainder (DIVU); 0 for all other ops.
- zero  out  1  registered with the result; 1 iff saida_ula == 0.
- overflow  out  1  signed two's-complement overflow of ADD/SUB; 0 for other ops.
- div_zero  out  1  DIVU issued with entrada2 == 0.
- ocupado  out  1  multi-cycle operation in progress.
- pronto  out  1  one-cycle pulse marking the cycle in which new results are valid.

## Operation
- State machine: OCIOSO, MULT, DIV, FIM.
  - OCIOSO: inicio=1 latches entrada1, entrada2 and sinal_ula.
    - Single-cycle ops (000–101) go to FIM with the result computed.
    - 110 goes to MULT.
    - 111 with entrada2≠0 goes to DIV; with entrada2==0 it goes straight to FIM.
  - MULT: shift-add, one partial-product bit per cycle, LARGURA iterations. Uses a 2·LARGURA-bit accumulator and a LARGURA-bit counter. Goes to FIM after the last iteration.
  - DIV: restoring division, one quotient bit per cycle, LARGURA iterations, then FIM.
  - FIM: outputs are updated and pronto=1 for exactly one cycle; returns to OCIOSO.
- Acceptance: inicio is accepted in OCIOSO and in FIM. A start asserted in the pronto cycle is therefore accepted, giving back-to-back issue. inicio in MULT or DIV is ignored and not queued.
- Operand capture: entrada1, entrada2 and sinal_ula may change freely after acceptance with no effect on the operation in flight.
- Arithmetic:
  - ADD/SUB wrap modulo 2^LARGURA.
  - overflow = operands of the same sign (ADD) or opposite sign (SUB) with result sign differing from entrada1.
  - SLT/SLTU return 1 or 0 zero-extended to LARGURA.
- Divide by zero: saida_ula = all ones, saida_hi = entrada1, div_zero=1, completes with single-cycle latency.
- Result hold: saida_ula, saida_hi, zero, overflow and div_zero hold their value until the next FIM. Flags that do not apply to the current op are driven 0 at FIM.
- Reset (asynchronous, any state, including mid-MULT or mid-DIV):
  - state OCIOSO, counter and accumulators cleared, operation in flight discarded.
  - all outputs 0, except zero, which resets to 1 because saida_ula is 0.

## Timing
- Acceptance edge is cycle 0.
- Single-cycle ops and DIVU-by-zero: pronto=1 and results valid in cycle 1; ocupado stays 0.
- MULTU and DIVU: ocupado=1 in cycles 1..LARGURA; pronto=1 and results valid in cycle LARGURA+1, with ocupado=0 in that cycle.
- Throughput:
  - single-cycle ops: one result per cycle when inicio is held high.
  - multi-cycle ops: one result per LARGURA+1 cycles.
- pronto is never high in two consecutive cycles for the same operation.
- pronto and ocupado are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- AND 0x0006/0x0003, then OR 0x0004/0x000B on back-to-back cycles.
  - Required: 0x0002 then 0x000F in consecutive pronto cycles.
  - Required: ocupado stays 0 throughout.
- ADD 0x7FFF+0x0001 gives 0x8000, overflow=1. SUB 0x0004−0x0004 gives 0x0000, zero=1, overflow=0.
- SLT 0xFFFF vs 0x0001 gives 0x0001. SLTU with the same operands gives 0x0000.
- MULTU 0x0123×0x0456 (LARGURA=16):
  - ocupado high for 16 cycles, then pronto.
  - saida_hi=0x0004, saida_ula=0xEDC2.
  - operand changes made mid-operation have no effect.
- DIVU 0x0017/0x0004 gives quotient 0x0005, remainder 0x0003 after 17 cycles. DIVU 0x1234/0x0000 gives 0xFFFF/0x1234, div_zero=1, pronto in cycle 1.
- reset_n low in cycle 5 of a MULTU.
  - Required, asynchronously: all outputs 0, zero=1, ocupado=0, and no pronto follows.
  - Then an ADD 2+3 issued after release returns 0x0005 in cycle 1.
